// File: rtl/sram_rd_streamer.sv
// Read initiator for the single-port SRAM wrapper: streams a run of words out over valid/ready.
// Optional per-run address stride is enabled with `define SRAM_RD_STRIDE_EN.
module sram_rd_streamer #(
  parameter int DW    = 64,
  parameter int MW    = 8,
  parameter int AW    = 12,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
`ifdef SRAM_RD_STRIDE_EN
  input  logic [AW-1:0] stride,
`endif
  output logic          busy,
  output logic          done,
  output logic          sram_cs,
  output logic          sram_we,
  output logic [MW-1:0] sram_wem,
  output logic [AW-1:0] sram_addr,
  input  logic [DW-1:0] sram_dout,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            accept;
  logic            pop;
  logic            push;
  logic            last_pop;
  logic            credit_ok;
  logic            done_d;
  logic [AW-1:0]   step;
  logic [AW-1:0]   next_addr_q;
  logic [AW-1:0]   last_addr_q;
  logic [AW:0]     issue_left_q;
  logic [AW:0]     pop_left_q;
  logic            inflight_q;
  logic            done_q;

  logic [DW-1:0]   mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef SRAM_RD_STRIDE_EN
  logic [AW-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = AW'(1);
`endif

  assign sram_we   = 1'b0;
  assign sram_wem  = '0;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign push      = inflight_q;
  assign out_valid = (cnt_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign pop       = out_valid & out_ready;

  // Credit uses registered occupancy only; a pop in the same cycle is not counted.
  assign credit_ok = ({1'b0, cnt_q} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(DEPTH);

  // Show the address being read while issuing, otherwise keep the last issued one.
  assign sram_addr = sram_cs ? next_addr_q : last_addr_q;

  // NOTE: every signal assigned in this always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    sram_cs  = 1'b0;
    last_pop = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        accept = start & ~done_q;
        if (accept) begin
          if (len == '0) done_d  = 1'b1;
          else           state_d = RUN;
        end
      end
      RUN, DRAIN: begin
        sram_cs  = (state_q == RUN) && (issue_left_q != '0) && credit_ok;
        last_pop = pop && (pop_left_q == (AW+1)'(1));
        if (last_pop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (state_q == RUN && issue_left_q == '0) begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_addr_q  <= '0;
      last_addr_q  <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      inflight_q   <= 1'b0;
`ifdef SRAM_RD_STRIDE_EN
      stride_q     <= '0;
`endif
    end else begin
      inflight_q <= sram_cs;
      if (accept) begin
        next_addr_q  <= base_addr;
        issue_left_q <= len;
        pop_left_q   <= len;
`ifdef SRAM_RD_STRIDE_EN
        stride_q     <= stride;
`endif
      end else begin
        if (sram_cs) begin
          next_addr_q  <= next_addr_q + step;
          last_addr_q  <= next_addr_q;
          issue_left_q <= issue_left_q - (AW+1)'(1);
        end
        if (pop) pop_left_q <= pop_left_q - (AW+1)'(1);
      end
    end
  end

  // NOTE: the storage array is not reset; cnt_q gates visibility, and out_data reads 0 while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= sram_dout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rd_streamer.sv
// Directed self-checking bench for sram_rd_streamer with an SRAM model returning data = address.
// Build with +define+SRAM_RD_STRIDE_EN to also exercise the stride port.
module tb_sram_rd_streamer;

  localparam int DW    = 64;
  localparam int MW    = 8;
  localparam int AW    = 12;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic [AW-1:0] stride_v;
  logic          busy, done, sram_cs, sram_we;
  logic [MW-1:0] sram_wem;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dout;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  int total = 0;
  int bad   = 0;

  logic [AW-1:0] addr_q[$];
  logic [DW-1:0] data_q[$];

  int tb_occ, tb_inf;
  bit prev_stall;
  logic [DW-1:0] prev_data;

  int cyc, first_cs, first_valid, busy_cnt;

  sram_rd_streamer #(.DW(DW), .MW(MW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .len       (len),
`ifdef SRAM_RD_STRIDE_EN
    .stride    (stride_v),
`endif
    .busy      (busy),
    .done      (done),
    .sram_cs   (sram_cs),
    .sram_we   (sram_we),
    .sram_wem  (sram_wem),
    .sram_addr (sram_addr),
    .sram_dout (sram_dout),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: one-cycle read latency, content equals address.
  always @(posedge clk) if (sram_cs) sram_dout <= DW'(sram_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Monitor: collects issued addresses and popped words, checks hold-under-stall and credit bound.
  always @(negedge clk) begin
    if (!rst_n) begin
      tb_occ = 0;
      tb_inf = 0;
      prev_stall = 1'b0;
    end else begin
      if (sram_cs) addr_q.push_back(sram_addr);
      if (out_valid && out_ready) data_q.push_back(out_data);
      if (prev_stall) check("hold_data", out_data, prev_data);
      check("credit_bound", 64'(tb_occ + tb_inf <= DEPTH), 64'd1);
      check("valid_vs_occ", 64'(out_valid), 64'(tb_occ != 0));
      tb_occ = tb_occ + tb_inf - int'(out_valid && out_ready);
      tb_inf = int'(sram_cs);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic run_cmd(input logic [AW-1:0] b, input logic [AW:0] l, input logic [AW-1:0] s,
                         input bit rnd, input int ghost, input int budget);
    addr_q.delete();
    data_q.delete();
    first_cs = -1;
    first_valid = -1;
    busy_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; len = l; stride_v = s;
    out_ready = rnd ? ($urandom_range(0, 9) < 3) : 1'b1;
    for (cyc = 1; cyc <= budget; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == ghost);
      if (start) begin
        base_addr = 12'h123;
        len = 13'd5;
      end
      if (rnd) out_ready = ($urandom_range(0, 9) < 3);
      @(negedge clk);
      if (sram_cs && first_cs < 0) first_cs = cyc;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (done) break;
      if (busy) busy_cnt++;
    end
    check("run_done", 64'(done), 64'd1);
    out_ready = 1'b1;
  endtask

  task automatic check_stream(input logic [AW-1:0] b, input logic [AW:0] l, input logic [AW-1:0] s);
    int nerr;
    int n;
    logic [AW-1:0] exp_a;
    nerr = 0;
    check("n_words", 64'(data_q.size()), 64'(l));
    check("n_reads", 64'(addr_q.size()), 64'(l));
    n = (data_q.size() < addr_q.size()) ? data_q.size() : addr_q.size();
    for (int i = 0; i < n; i++) begin
      exp_a = b + AW'(i) * s;
      if (addr_q[i] !== exp_a || data_q[i] !== DW'(exp_a)) nerr++;
    end
    check("order_errors", 64'(nerr), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; len = '0; stride_v = 12'd1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_cs", 64'(sram_cs), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_data", out_data, 64'd0);
    check("rst_we_wem", {55'd0, sram_we, sram_wem}, 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic run: latency, throughput, busy/done framing.
    run_cmd(12'h010, 13'd8, 12'd1, 1'b0, 0, 100);
    check("t1_busy_at_done", 64'(busy), 64'd0);
    check("t1_first_cs", 64'(first_cs), 64'd1);
    check("t1_first_valid", 64'(first_valid), 64'd3);
    check("t1_done_cycle", 64'(cyc), 64'd11);
    check("t1_busy_cycles", 64'(busy_cnt), 64'd10);
    check_stream(12'h010, 13'd8, 12'd1);
    @(negedge clk);
    check("t1_done_pulse", 64'(done), 64'd0);

    // Backpressure with ~30% ready.
    run_cmd(12'h200, 13'd16, 12'd1, 1'b1, 0, 2000);
    check_stream(12'h200, 13'd16, 12'd1);

    // Address wrap.
    run_cmd(12'hFFE, 13'd4, 12'd1, 1'b0, 0, 100);
    check("t3_nreads", 64'(addr_q.size()), 64'd4);
    if (addr_q.size() == 4) begin
      check("t3_a0", 64'(addr_q[0]), 64'hFFE);
      check("t3_a1", 64'(addr_q[1]), 64'hFFF);
      check("t3_a2", 64'(addr_q[2]), 64'h000);
      check("t3_a3", 64'(addr_q[3]), 64'h001);
    end
    check_stream(12'hFFE, 13'd4, 12'd1);

    // Zero length: done one cycle after accept, no reads, never busy.
    run_cmd(12'h055, 13'd0, 12'd1, 1'b0, 0, 20);
    check("t3_zero_cycle", 64'(cyc), 64'd1);
    check("t3_zero_busy", 64'(busy_cnt), 64'd0);
    repeat (3) @(negedge clk);
    check("t3_zero_nocs", 64'(addr_q.size()), 64'd0);

    // Full range with an ignored start mid-run.
    run_cmd(12'h000, 13'd4096, 12'd1, 1'b0, 100, 6000);
    check("t4_done_cycle", 64'(cyc), 64'd4099);
    check_stream(12'h000, 13'd4096, 12'd1);
    repeat (5) @(negedge clk);
    check("t4_idle_after", 64'(busy), 64'd0);

    // Reset in the middle of a run.
    addr_q.delete();
    data_q.delete();
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'h040; len = 13'd20; stride_v = 12'd1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (data_q.size() >= 5) break;
    end
    check("t5_five_popped", 64'(data_q.size() >= 5), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_cs", 64'(sram_cs), 64'd0);
    check("t5_valid", 64'(out_valid), 64'd0);
    check("t5_addr", 64'(sram_addr), 64'd0);
    check("t5_data", out_data, 64'd0);
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    run_cmd(12'h100, 13'd3, 12'd1, 1'b0, 0, 100);
    check_stream(12'h100, 13'd3, 12'd1);

`ifdef SRAM_RD_STRIDE_EN
    // Strided run wrapping back to base.
    run_cmd(12'h000, 13'd5, 12'h400, 1'b0, 0, 100);
    check("t6_nreads", 64'(addr_q.size()), 64'd5);
    if (addr_q.size() == 5) begin
      check("t6_a0", 64'(addr_q[0]), 64'h000);
      check("t6_a1", 64'(addr_q[1]), 64'h400);
      check("t6_a2", 64'(addr_q[2]), 64'h800);
      check("t6_a3", 64'(addr_q[3]), 64'hC00);
      check("t6_a4", 64'(addr_q[4]), 64'h000);
    end
    check_stream(12'h000, 13'd5, 12'h400);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_rd_streamer.md
Name: sram_rd_streamer

Overview:
Read initiator for the single-port 4Kx64 SRAM wrapper: the SRAM is the responder, this block drives its request side. On a start command it reads a run of words from the SRAM and presents them in order on a valid/ready stream toward the compute datapath. It hides the SRAM's 1-cycle read latency and absorbs downstream backpressure with a small credit-checked FIFO. It is used by the feature-map and weight fetch paths of the accelerator.

Parameters:
DW, 64, SRAM data width
MW, 8, SRAM write-mask width (DW/8)
AW, 12, SRAM address width
DEPTH, 4, output FIFO entries; minimum 3, which gives full throughput

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  command pulse; accepted only when busy=0
base_addr  in  AW  first word address, captured on accept
len  in  AW+1  number of words to read, 0..2^AW, captured on accept
busy  out  1  high from cycle after accept until done
done  out  1  one-cycle pulse when the last word is consumed
sram_cs  out  1  SRAM chip select, one read per cycle where high
sram_we  out  1  SRAM write enable, constant 0
sram_wem  out  MW  SRAM write mask, constant 0
sram_addr  out  AW  SRAM address
sram_dout  in  DW  SRAM read data, valid the cycle after sram_cs
out_valid  out  1  stream data valid
out_data  out  DW  stream data, FIFO head
out_ready  in  1  downstream accept

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy, done, sram_cs, out_valid = 0; sram_addr=0; FIFO empty; counters 0; out_data=0.
- States:
  - IDLE: on start, capture base/len. If len=0, pulse done next cycle and issue no reads; busy stays 0. Otherwise go to RUN and set busy=1.
  - RUN: issue reads until the remaining-issue count is 0, then go to DRAIN.
  - DRAIN: wait until the FIFO is empty and nothing is in flight with the last word popped. Then go to IDLE, drive done=1 for 1 cycle, busy=0 in the same cycle.
- start while busy=1 or while done=1 is ignored.
- Issue rule: sram_cs=1 in a cycle only if state=RUN, remaining>0 and (fifo_cnt + inflight) < DEPTH.
  - fifo_cnt and inflight are registered values. Same-cycle pops are not credited, which is conservative.
- Overflow is therefore impossible by construction. The bench asserts it.
- Addressing: sram_addr steps base, base+1, … modulo 2^AW. Wrap 0xFFF→0x000 is legal.
- sram_addr holds its last value when sram_cs=0.
- Read pipeline: inflight <= sram_cs. When inflight=1, sram_dout is written to the FIFO tail at the end of that cycle.
- Latency: first sram_cs is 1 cycle after the start accept. First out_valid is 2 cycles after the first sram_cs.
- Stream: out_valid = FIFO non-empty; out_data = head. A pop occurs when out_valid & out_ready.
- Simultaneous push and pop leave fifo_cnt unchanged.
- out_data is stable while out_valid=1 and out_ready=0.
- Throughput: with out_ready held 1 and DEPTH≥3, one word per cycle sustained.
- Word order is strictly ascending issue order; no reordering or duplication.
- done asserts the cycle after the pop of word len-1.
- Reset mid-operation discards all in-flight and buffered data. The SRAM is left idle; sram_cs=0 immediately.

Optional Feature:
SRAM_RD_STRIDE_EN
- Defined: adds input stride [AW-1:0], captured on accept. Addresses go base, base+stride, base+2·stride, … modulo 2^AW. stride=0 rereads base len times.
- Undefined: no stride port; stride is fixed at 1.

Test Plan:
- Basic run: base=0x010, len=8, out_ready=1, SRAM preloaded data=addr → out_data 0x010..0x017 on 8 consecutive cycles. First sram_cs 1 cycle after start; first out_valid 3 cycles after start; done one cycle after last pop; busy spans exactly.
- Backpressure: len=16, out_ready toggles pseudo-randomly, 30% high → all 16 words in order, no loss or duplication. out_data stable while stalled. fifo_cnt+inflight never exceeds DEPTH.
- Wrap and zero: base=0xFFE, len=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001. Then len=0 → done pulse 1 cycle after start, no sram_cs.
- Full range and ignored start: len=4096 from base 0 → 4096 words. A start pulsed mid-run with different base/len has no effect.
- Reset mid-run: assert rst_n=0 after 5 words popped of len=20 → outputs immediately at reset values. A new run base=0x100, len=3 then returns 0x100..0x102.
- Stride (SRAM_RD_STRIDE_EN defined): base=0x000, stride=0x400, len=5 → addresses 0x000, 0x400, 0x800, 0xC00, 0x000.
